adc_idelay_tap_tuner: RTL and testbench
=======================================

Name: adc_idelay_tap_tuner

Overview:
- Per-lane ADC data-eye training controller, successor to the fixed-tap data IODELAY instantiation.
- Sweeps every IODELAYE1 tap across all lanes in parallel while the ADC emits a toggling training pattern (0x55/0xAA style).
- Finds the widest passing window per lane and loads that window's centre tap.
- Drives VAR_LOADABLE IODELAYE1 controls (CNTVALUEIN, RST-as-load) on adc_clk_bufr; sits between the IBUFDS bank and the ISERDES/capture logic.

Parameters:
- ADC_DATA_WIDTH, 8: number of data lanes.
- TAP_BITS, 5: IODELAY counter width.
- NUM_TAPS, 32: taps swept, 0..NUM_TAPS-1; must be ≤ 2^TAP_BITS.
- SETTLE_CYCLES, 16: wait after each tap load before checking.
- CHECK_CYCLES, 64: samples checked per tap.
- MIN_EYE, 4: minimum passing-window length for a lane to be accepted.
- DEFAULT_TAPS, {ADC_DATA_WIDTH*TAP_BITS{1'b0}}: packed per-lane fallback taps, lane 0 in the LSBs.

Ports:
- adc_clk_bufr, input, 1: regional ADC clock; all logic runs on it.
- rst_n, input, 1: asynchronous, active-low reset.
- train_start, input, 1: one-cycle pulse that starts training.
- adc_sample, input, ADC_DATA_WIDTH: captured delayed data, one bit per lane, one sample per cycle.
- idelay_cntvalue_all, output, ADC_DATA_WIDTH*TAP_BITS: per-lane tap value, lane j at [j*TAP_BITS +: TAP_BITS].
- idelay_ld, output, 1: one-cycle load strobe to all IODELAYE1 RST pins.
- busy, output, 1: training in progress.
- train_done, output, 1: training finished.
- train_err, output, ADC_DATA_WIDTH: per-lane flag, set when the lane's best window < MIN_EYE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idelay_cntvalue_all=DEFAULT_TAPS; idelay_ld=0; busy=0; train_done=0; train_err=0.
  - All lane trackers cleared. Takes effect mid-operation from any state.
- Load after reset: first cycle after rst_n deasserts, state=INIT, idelay_ld pulses once so DEFAULT_TAPS are applied, then IDLE.
- FSM states: IDLE, INIT, LOAD, SETTLE, CHECK, NEXT, CALC, APPLY, DONE.
- IDLE/DONE + train_start: tap=0, busy=1, train_done=0, train_err cleared, go to LOAD. train_start while busy is ignored.
- LOAD (1 cycle): all lanes' cntvalue=tap; idelay_ld=1; go to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then CHECK. Lane pass flags are set to 1 on entry to CHECK.
- CHECK (CHECK_CYCLES cycles): lane j pass flag clears if adc_sample[j] equals its value from the previous cycle. The first CHECK sample is compared against the last SETTLE sample.
- NEXT (1 cycle):
  - Each lane tracker updates. Pass: run_len++, run_start=tap if run_len was 0. Fail: close the run.
  - A closed run replaces best only if strictly longer, so on ties the first/lowest window wins.
  - If tap==NUM_TAPS-1, close all open runs and go to CALC; else tap++ and go to LOAD.
- CALC (1 cycle):
  - Lane with best_len ≥ MIN_EYE: centre = best_start + (best_len>>1), truncated to TAP_BITS.
  - Lane with best_len < MIN_EYE: centre = its DEFAULT_TAPS field and train_err[j]=1.
- APPLY (1 cycle): cntvalue=centres, idelay_ld=1, go to DONE.
- DONE: busy=0; train_done=1, held until the next train_start or reset.
- Duration: one full sweep = NUM_TAPS*(1+SETTLE_CYCLES+CHECK_CYCLES+1)+2 cycles from train_start to train_done.
- Arithmetic: counters sized with clog2(max+1). Run lengths are TAP_BITS+1 bits wide so a 32-long window does not wrap.
- Outside LOAD/APPLY/INIT and manual load, idelay_ld=0 and cntvalue holds its last value.

Optional Feature:
- Macro: ADC_TAP_MANUAL_EN.
- With the macro defined:
  - Adds ports manual_ld (input, 1) and manual_cntvalue_all (input, ADC_DATA_WIDTH*TAP_BITS).
  - manual_ld in IDLE/DONE copies manual_cntvalue_all to idelay_cntvalue_all and pulses idelay_ld on the next cycle; train_err/train_done are unchanged.
  - manual_ld is ignored while busy. If train_start and manual_ld arrive in the same cycle, train_start wins.
- Without the macro: no extra ports; taps change only by training or reset.

Decomposition:
- Package adc_iodelay_pkg: TAP_BITS/NUM_TAPS defaults, the FSM state enum, and the tap-field slice helper function.
- Sub-module adc_lane_eye_tracker, one instance per lane via generate:
  - Holds the pass flag, run_start/run_len and best_start/best_len.
  - Computes that lane's centre and error.

Test Plan:
- All lanes toggle at every tap → each lane window 0..31, len 32, centre 16, train_err=0, exactly 33 idelay_ld pulses after train_start.
- Lane 3 toggles only for taps 5..14, others for all taps → lane 3 centre 10, other lanes 16.
- Lane 2 passes taps 2..6 and 20..24 (tie, len 5) → centre 4.
- Lane 0 stuck at 1 with DEFAULT_TAPS lane 0 = 7 → train_err[0]=1 and lane 0 tap=7; lane 1 passing only 0..2 (< MIN_EYE) → train_err[1]=1.
- rst_n low during CHECK of tap 9 → outputs return to reset values immediately, then one INIT idelay_ld pulse; a second train_start pulse mid-sweep is ignored with no restart.
- With ADC_TAP_MANUAL_EN: manual_ld with lane 5 = 21 in DONE → lane 5 cntvalue=21 plus one idelay_ld pulse; the same request while busy → no change.

Source files
------------

// File: rtl/adc_iodelay_pkg.sv
// adc_iodelay_pkg: IODELAY tap-tuner defaults, FSM states and the per-lane tap-field helper
package adc_iodelay_pkg;
  localparam int TAP_BITS_DEF = 5;
  localparam int NUM_TAPS_DEF = 32;
  localparam int MAX_BUS = 256;
  localparam int MAX_TAP = 8;
  typedef enum logic [3:0] {IDLE, INIT, LOAD, SETTLE, CHECK, NEXT, CALC, APPLY, DONE} tuner_state_t;
  function automatic logic [MAX_TAP-1:0] tap_field(input logic [MAX_BUS-1:0] bus, input int lane, input int bits);
    logic [MAX_BUS-1:0] m;
    m = (MAX_BUS'(1) << bits) - MAX_BUS'(1);
    return MAX_TAP'((bus >> (lane * bits)) & m);
  endfunction
endpackage

// File: rtl/adc_lane_eye_tracker.sv
// adc_lane_eye_tracker: one lane's pass flag, current/best passing run and centre-tap choice
module adc_lane_eye_tracker #(
  parameter int TAP_BITS = 5,
  parameter int MIN_EYE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                arm,
  input  logic                check,
  input  logic                step,
  input  logic                last,
  input  logic                sample,
  input  logic                prev,
  input  logic [TAP_BITS-1:0] tap,
  input  logic [TAP_BITS-1:0] dflt,
  output logic [TAP_BITS-1:0] centre,
  output logic                err
);
  localparam int LW = TAP_BITS + 1;
  logic pass;
  logic [TAP_BITS-1:0] run_start, best_start, cl_start;
  logic [LW-1:0] run_len, best_len, cl_len;
  always_comb begin
    cl_len = pass ? run_len + 1'b1 : run_len;
    cl_start = (pass && run_len == '0) ? tap : run_start;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pass <= 1'b0;
      run_start <= '0;
      run_len <= '0;
      best_start <= '0;
      best_len <= '0;
    end else if (clear) begin
      pass <= 1'b0;
      run_start <= '0;
      run_len <= '0;
      best_start <= '0;
      best_len <= '0;
    end else begin
      if (arm) pass <= 1'b1;
      else if (check && sample == prev) pass <= 1'b0;
      // strict > keeps the lowest window on equal lengths
      if (step) begin
        if (!pass || last) begin
          run_len <= '0;
          if (cl_len > best_len) begin
            best_len <= cl_len;
            best_start <= cl_start;
          end
        end else begin
          run_len <= cl_len;
          run_start <= cl_start;
        end
      end
    end
  assign err = best_len < LW'(MIN_EYE);
  assign centre = err ? dflt : best_start + TAP_BITS'(best_len >> 1);
endmodule

// File: rtl/adc_idelay_tap_tuner.sv
// adc_idelay_tap_tuner: sweeps IODELAYE1 taps on all ADC lanes and loads each lane's eye centre
// Optional ADC_TAP_MANUAL_EN adds manual_ld/manual_cntvalue_all for direct tap loads in IDLE/DONE.
module adc_idelay_tap_tuner
  import adc_iodelay_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int TAP_BITS = TAP_BITS_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_CYCLES = 64,
  parameter int MIN_EYE = 4,
  parameter logic [ADC_DATA_WIDTH*TAP_BITS-1:0] DEFAULT_TAPS = '0
) (
  input  logic                               adc_clk_bufr,
  input  logic                               rst_n,
  input  logic                               train_start,
  input  logic [ADC_DATA_WIDTH-1:0]          adc_sample,
  output logic [ADC_DATA_WIDTH*TAP_BITS-1:0] idelay_cntvalue_all,
  output logic                               idelay_ld,
  output logic                               busy,
  output logic                               train_done,
  output logic [ADC_DATA_WIDTH-1:0]          train_err
`ifdef ADC_TAP_MANUAL_EN
  ,
  input  logic                               manual_ld,
  input  logic [ADC_DATA_WIDTH*TAP_BITS-1:0] manual_cntvalue_all
`endif
);
  localparam int BW = ADC_DATA_WIDTH * TAP_BITS;
  localparam int CMAX = SETTLE_CYCLES > CHECK_CYCLES ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  tuner_state_t state, state_nxt;
  logic boot, man_pend, man_req, idle_like, start_ok, cyc_last, last, arm, chk, step;
  logic [TAP_BITS-1:0] tap, tap_nxt;
  logic [CW-1:0] cyc;
  logic [BW-1:0] centres, man_cnt;
  logic [ADC_DATA_WIDTH-1:0] prev, errs;
  assign idle_like = (state == IDLE && !boot) || state == DONE;
  assign start_ok = idle_like && train_start;
  assign last = tap == TAP_BITS'(NUM_TAPS - 1);
  assign cyc_last = cyc == CW'(state == SETTLE ? SETTLE_CYCLES - 1 : CHECK_CYCLES - 1);
  assign tap_nxt = start_ok ? '0 : tap + 1'b1;
  assign arm = state == SETTLE && cyc_last;
  assign chk = state == CHECK;
  assign step = state == NEXT;
`ifdef ADC_TAP_MANUAL_EN
  assign man_req = idle_like && manual_ld && !train_start;
  assign man_cnt = manual_cntvalue_all;
`else
  assign man_req = 1'b0;
  assign man_cnt = '0;
`endif
  always_ff @(posedge adc_clk_bufr or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    idelay_ld = man_pend;
    busy = 1'b1;
    train_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        state_nxt = boot ? INIT : start_ok ? LOAD : IDLE;
      end
      INIT: begin
        busy = 1'b0;
        idelay_ld = 1'b1;
        state_nxt = IDLE;
      end
      LOAD: begin
        idelay_ld = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: state_nxt = cyc_last ? CHECK : SETTLE;
      CHECK: state_nxt = cyc_last ? NEXT : CHECK;
      NEXT: state_nxt = last ? CALC : LOAD;
      CALC: state_nxt = APPLY;
      APPLY: begin
        idelay_ld = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b0;
        train_done = 1'b1;
        state_nxt = start_ok ? LOAD : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge adc_clk_bufr or negedge rst_n)
    if (!rst_n) begin
      boot <= 1'b1;
      man_pend <= 1'b0;
      tap <= '0;
      cyc <= '0;
      prev <= '0;
      idelay_cntvalue_all <= DEFAULT_TAPS;
      train_err <= '0;
    end else begin
      boot <= 1'b0;
      man_pend <= man_req;
      prev <= adc_sample;
      cyc <= ((state == SETTLE || state == CHECK) && !cyc_last) ? cyc + 1'b1 : '0;
      // cntvalue is written on entry to LOAD/APPLY so it is stable while idelay_ld is high
      if (state_nxt == LOAD) begin
        tap <= tap_nxt;
        idelay_cntvalue_all <= {ADC_DATA_WIDTH{tap_nxt}};
      end else if (state == CALC) begin
        idelay_cntvalue_all <= centres;
        train_err <= errs;
      end else if (man_req) idelay_cntvalue_all <= man_cnt;
      if (start_ok) train_err <= '0;
    end
  for (genvar j = 0; j < ADC_DATA_WIDTH; j++) begin : g_lane
    adc_lane_eye_tracker #(.TAP_BITS(TAP_BITS), .MIN_EYE(MIN_EYE)) u_trk (
      .clk(adc_clk_bufr),
      .rst_n(rst_n),
      .clear(start_ok),
      .arm(arm),
      .check(chk),
      .step(step),
      .last(last),
      .sample(adc_sample[j]),
      .prev(prev[j]),
      .tap(tap),
      .dflt(TAP_BITS'(tap_field(MAX_BUS'(DEFAULT_TAPS), j, TAP_BITS))),
      .centre(centres[j*TAP_BITS +: TAP_BITS]),
      .err(errs[j])
    );
  end
endmodule

// File: tb/tb_adc_idelay_tap_tuner.sv
// tb_adc_idelay_tap_tuner: directed sweeps with an eye-model scoreboard for the tap tuner
`timescale 1ns/1ps
module tb_adc_idelay_tap_tuner;
  localparam int W = 8, TB = 5, NT = 32, SC = 16, CC = 64, ME = 4;
  localparam int BW = W * TB;
  localparam logic [BW-1:0] DFLT = 40'h7;
  localparam int DUR = NT * (1 + SC + CC + 1) + 2;
  typedef struct {
    string tag;
    logic [BW-1:0] cnt;
    logic [W-1:0] err;
  } exp_t;
  exp_t exp_q[$];
  logic adc_clk_bufr = 1'b0, rst_n = 1'b0, train_start = 1'b0, tog = 1'b0;
  logic [W-1:0] adc_sample = '0;
  logic [BW-1:0] idelay_cntvalue_all;
  logic idelay_ld, busy, train_done;
  logic [W-1:0] train_err;
  logic [NT-1:0] mask [W];
  int checks = 0, failures = 0, ld_cnt = 0;
  bit man_during = 1'b0;
`ifdef ADC_TAP_MANUAL_EN
  logic manual_ld = 1'b0;
  logic [BW-1:0] manual_cntvalue_all = '0;
`endif
  adc_idelay_tap_tuner #(.DEFAULT_TAPS(DFLT)) dut (
    .adc_clk_bufr(adc_clk_bufr),
    .rst_n(rst_n),
    .train_start(train_start),
    .adc_sample(adc_sample),
    .idelay_cntvalue_all(idelay_cntvalue_all),
    .idelay_ld(idelay_ld),
    .busy(busy),
    .train_done(train_done),
    .train_err(train_err)
`ifdef ADC_TAP_MANUAL_EN
    ,
    .manual_ld(manual_ld),
    .manual_cntvalue_all(manual_cntvalue_all)
`endif
  );
  always #5 adc_clk_bufr = ~adc_clk_bufr;
  // ADC model: a lane toggles at taps inside its eye mask, otherwise sits at 1
  initial forever begin
    @(negedge adc_clk_bufr);
    tog = ~tog;
    for (int j = 0; j < W; j++) adc_sample[j] = mask[j][idelay_cntvalue_all[j*TB +: TB]] ? tog : 1'b1;
  end
  initial forever begin
    @(negedge adc_clk_bufr);
    if (idelay_ld) ld_cnt++;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(negedge adc_clk_bufr);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(output logic [BW-1:0] c, output logic [W-1:0] e);
    logic [BW-1:0] d;
    int run, st, bl, bs;
    d = DFLT;
    c = '0;
    e = '0;
    for (int j = 0; j < W; j++) begin
      run = 0; st = 0; bl = 0; bs = 0;
      for (int t = 0; t <= NT; t++) begin
        if (t < NT && mask[j][t]) begin
          if (run == 0) st = t;
          run++;
        end else begin
          if (run > bl) begin
            bl = run;
            bs = st;
          end
          run = 0;
        end
      end
      if (bl < ME) begin
        c[j*TB +: TB] = d[j*TB +: TB];
        e[j] = 1'b1;
      end else c[j*TB +: TB] = TB'(bs + bl / 2);
    end
  endfunction
  task automatic sweep(input string tag, input int re_pulse);
    exp_t e;
    int cyc;
    model(e.cnt, e.err);
    e.tag = tag;
    exp_q.push_back(e);
    ld_cnt = 0;
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    cyc = 0;
    while (!train_done && cyc < DUR + 100) begin
      tick();
      cyc++;
      train_start = cyc == re_pulse;
`ifdef ADC_TAP_MANUAL_EN
      manual_ld = man_during && cyc == 300;
      manual_cntvalue_all = '1;
`endif
      if (cyc == 10) chk({tag, "_busy_mid"}, 64'(busy), 64'(1));
    end
    train_start = 1'b0;
    e = exp_q.pop_front();
    chk({e.tag, "_duration"}, 64'(cyc), 64'(DUR));
    chk({e.tag, "_taps"}, 64'(idelay_cntvalue_all), 64'(e.cnt));
    chk({e.tag, "_err"}, 64'(train_err), 64'(e.err));
    chk({e.tag, "_ld_pulses"}, 64'(ld_cnt), 64'(NT + 1));
    chk({e.tag, "_busy_end"}, 64'(busy), 64'(0));
  endtask
  initial begin
    logic [BW-1:0] mc;
    logic [W-1:0] me;
    bit found;
    for (int j = 0; j < W; j++) mask[j] = '1;
    repeat (3) tick();
    chk("reset_taps", 64'(idelay_cntvalue_all), 64'(DFLT));
    chk("reset_ld", 64'(idelay_ld), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(train_done), 64'(0));
    chk("reset_err", 64'(train_err), 64'(0));
    ld_cnt = 0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("init_ld_pulses", 64'(ld_cnt), 64'(1));
    chk("init_taps", 64'(idelay_cntvalue_all), 64'(DFLT));
    sweep("all_toggle", 500);
    mask[3] = 32'h0000_7FE0;
    sweep("lane3_window", 0);
    for (int j = 0; j < W; j++) mask[j] = '1;
    mask[2] = 32'h01F0_007C;
    mask[0] = '0;
    mask[1] = 32'h0000_0007;
    sweep("tie_and_narrow", 0);
    chk("done_held", 64'(train_done), 64'(1));
`ifdef ADC_TAP_MANUAL_EN
    model(mc, me);
    mc[5*TB +: TB] = 5'd21;
    ld_cnt = 0;
    manual_cntvalue_all = mc;
    manual_ld = 1'b1;
    tick();
    manual_ld = 1'b0;
    repeat (2) tick();
    chk("manual_taps", 64'(idelay_cntvalue_all), 64'(mc));
    chk("manual_ld_pulses", 64'(ld_cnt), 64'(1));
    chk("manual_done", 64'(train_done), 64'(1));
    chk("manual_err", 64'(train_err), 64'(me));
    man_during = 1'b1;
    sweep("manual_while_busy", 0);
    man_during = 1'b0;
`endif
    for (int j = 0; j < W; j++) mask[j] = '1;
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = idelay_ld && idelay_cntvalue_all[TB-1:0] == 5'd9;
    end
    chk("tap9_reached", 64'(found), 64'(1));
    repeat (1 + SC + 10) tick();
    chk("tap9_check_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_taps", 64'(idelay_cntvalue_all), 64'(DFLT));
    chk("midrst_ld", 64'(idelay_ld), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(train_done), 64'(0));
    chk("midrst_err", 64'(train_err), 64'(0));
    repeat (2) tick();
    ld_cnt = 0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midrst_init_ld", 64'(ld_cnt), 64'(1));
    chk("midrst_idle_busy", 64'(busy), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
